// File: rtl/ram_req_sequencer.sv
// ram_req_sequencer: sole driver of a single-port synchronous RAM.
// Turns a valid/ready request stream into RAM we/address/data pins, captures
// read data in the one cycle it is valid and buffers it in a 2-entry response
// FIFO with valid/ready backpressure.
// Build option: define RAM_SEQ_INIT_SWEEP_EN to sweep INIT_VALUE into every
// RAM word after reset; undefined, the block starts ready and RAM is unknown.
module ram_req_sequencer #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int MEMORY_DEPTH  = 32,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0]    req_data_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [DATA_WIDTH-1:0]    rsp_data_o,
   output logic                     ram_we_o,
   output logic [ADDRESS_WIDTH-1:0] ram_address_o,
   output logic [DATA_WIDTH-1:0]    ram_data_o,
   input  logic [DATA_WIDTH-1:0]    ram_data_i,
   output logic                     init_done_o
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

`ifdef RAM_SEQ_INIT_SWEEP_EN
   localparam state_t RESET_STATE = ST_INIT;
   logic [ADDRESS_WIDTH-1:0] init_cnt_q;
`else
   localparam state_t RESET_STATE = ST_RUN;
`endif

   state_t state_q;
   state_t state_d;

   logic                  rd_pend_q;
   logic [DATA_WIDTH-1:0] fifo_mem_q [2];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            fifo_cnt_q;
   logic [2:0]            credits_used;
   logic                  push;
   logic                  pop;

   // The response FIFO head is always visible; valid whenever it holds data.
   assign rsp_valid_o = (fifo_cnt_q != 2'd0);
   assign rsp_data_o  = fifo_mem_q[rd_ptr_q];

   // A read issued last cycle has its data on ram_data_i now, so push it.
   assign push = rd_pend_q;
   assign pop  = rsp_valid_o & rsp_ready_i;

   // Reads in flight plus stored responses; no credit is returned by a pop in the same cycle.
   assign credits_used = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q};

   // State register: INIT sweep (if built in) then RUN forever.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef RAM_SEQ_INIT_SWEEP_EN
   // Sweep address counter, advances once per INIT cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         init_cnt_q <= '0;
      end else if (state_q == ST_INIT) begin
         init_cnt_q <= init_cnt_q + 1'b1;
      end
   end
`endif

   // Next state and RAM/handshake drive; everything parks at zero while reset is held.
   always_comb begin
      state_d       = state_q;
      req_ready_o   = 1'b0;
      init_done_o   = 1'b0;
      ram_we_o      = 1'b0;
      ram_address_o = '0;
      ram_data_o    = '0;
      if (!rst_i) begin
         case (state_q)
            ST_INIT: begin
`ifdef RAM_SEQ_INIT_SWEEP_EN
               ram_we_o      = 1'b1;
               ram_address_o = init_cnt_q;
               ram_data_o    = INIT_VALUE;
               if (init_cnt_q == LAST_ADDR) begin
                  state_d = ST_RUN;
               end
`else
               ram_address_o = LAST_ADDR;
               ram_data_o    = INIT_VALUE;
               state_d       = ST_RUN;
`endif
            end
            ST_RUN: begin
               init_done_o   = 1'b1;
               req_ready_o   = req_we_i ? 1'b1 : (credits_used < 3'd2);
               ram_address_o = req_addr_i;
               ram_data_o    = req_data_i;
               ram_we_o      = req_valid_i & req_ready_o & req_we_i;
            end
            default: begin
               state_d = RESET_STATE;
            end
         endcase
      end
   end

   // Read pipeline flag and 2-entry response FIFO; reset drops anything in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_pend_q     <= 1'b0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         fifo_cnt_q    <= 2'd0;
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
      end else begin
         rd_pend_q <= req_valid_i & req_ready_o & ~req_we_i;
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= ram_data_i;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_req_sequencer.sv
// Directed bench for ram_req_sequencer with a behavioural single-port RAM.
// Handles both builds (RAM_SEQ_INIT_SWEEP_EN defined or not).
module tb_ram_req_sequencer;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 32;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic          req_we_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [DW-1:0] req_data_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   logic [DW-1:0] rsp_data_o;
   logic          ram_we_o;
   logic [AW-1:0] ram_address_o;
   logic [DW-1:0] ram_data_o;
   logic [DW-1:0] ram_data_i;
   logic          init_done_o;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] ram_mem [DEPTH];
   logic [DW-1:0] ram_rd_q;
   logic [DW-1:0] shadow  [DEPTH];
   logic [AW-1:0] rd_q [$];
   logic [DW-1:0] exp_q [$];

   // 100 MHz-style free-running clock
   always #5 clk_i = ~clk_i;

   ram_req_sequencer #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MEMORY_DEPTH(DEPTH),
      .INIT_VALUE('0)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_we_i(req_we_i),
      .req_addr_i(req_addr_i),
      .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o),
      .ram_we_o(ram_we_o),
      .ram_address_o(ram_address_o),
      .ram_data_o(ram_data_o),
      .ram_data_i(ram_data_i),
      .init_done_o(init_done_o)
   );

   // Single-port synchronous RAM: write when we, otherwise register the read word
   always @(posedge clk_i) begin
      if (ram_we_o) ram_mem[ram_address_o] <= ram_data_o;
      else          ram_rd_q <= ram_mem[ram_address_o];
   end
   assign ram_data_i = ram_rd_q;

   task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic rr);
      req_valid_i = v;
      req_we_i    = we;
      req_addr_i  = a;
      req_data_i  = d;
      rsp_ready_i = rr;
      #1;
   endtask

   task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
      applyStimulus(1'b1, 1'b1, a, d, 1'b1);
      checkOutput("wr_ready", DW'(req_ready_o), 1);
      shadow[a] = d;
      step();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   // Drain rd_q as reads with rsp_ready=1; return first-response latency, span and count
   task automatic runReads(input int budget, output int lat, output int span, output int nrsp);
      int c = 0;
      int first_acc = -1;
      int first_rsp = -1;
      int last_rsp = -1;
      nrsp = 0;
      while ((rd_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
         if (rd_q.size() > 0) applyStimulus(1'b1, 1'b0, rd_q[0], '0, 1'b1);
         else                 applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
         if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               checkOutput("rsp_unexpected", DW'(rsp_valid_o), 0);
            end else begin
               checkOutput("rsp_data", rsp_data_o, exp_q.pop_front());
               if (first_rsp < 0) first_rsp = c;
               last_rsp = c;
               nrsp++;
            end
         end
         if (rd_q.size() > 0 && req_ready_o) begin
            exp_q.push_back(shadow[rd_q.pop_front()]);
            if (first_acc < 0) first_acc = c;
         end
         step();
         c++;
      end
      if (rd_q.size() > 0 || exp_q.size() > 0) begin
         checkOutput("read_timeout", DW'(rd_q.size() + exp_q.size()), 0);
         rd_q.delete();
         exp_q.delete();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      lat  = first_rsp - first_acc;
      span = last_rsp - first_acc;
   endtask

   // Bring the block out of reset and through its start-up phase
   task automatic releaseReset(input string pfx);
      step();
      rst_i = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
`ifdef RAM_SEQ_INIT_SWEEP_EN
      for (int k = 0; k < DEPTH; k++) begin
         checkOutput({pfx, "_sweep_we"}, DW'(ram_we_o), 1);
         checkOutput({pfx, "_sweep_addr"}, DW'(ram_address_o), DW'(k));
         checkOutput({pfx, "_sweep_data"}, ram_data_o, 0);
         checkOutput({pfx, "_rsp_valid"}, DW'(rsp_valid_o), 0);
         if (k == 0 || k == DEPTH - 1) begin
            checkOutput({pfx, "_init_busy"}, DW'(init_done_o), 0);
            checkOutput({pfx, "_ready_init"}, DW'(req_ready_o), 0);
         end
         step();
      end
      for (int k = 0; k < DEPTH; k++) shadow[k] = '0;
`else
      for (int k = 0; k < 4; k++) begin
         checkOutput({pfx, "_rsp_valid"}, DW'(rsp_valid_o), 0);
         step();
      end
`endif
      checkOutput({pfx, "_init_done"}, DW'(init_done_o), 1);
      checkOutput({pfx, "_ready_run"}, DW'(req_ready_o), 1);
   endtask

   initial begin
      int lat;
      int span;
      int nrsp;

      #1 rst_i = 1'b1;
      #2;
      checkOutput("rst_req_ready", DW'(req_ready_o), 0);
      checkOutput("rst_rsp_valid", DW'(rsp_valid_o), 0);
      checkOutput("rst_rsp_data", rsp_data_o, 0);
      checkOutput("rst_ram_we", DW'(ram_we_o), 0);
      checkOutput("rst_ram_addr", DW'(ram_address_o), 0);
      checkOutput("rst_ram_data", ram_data_o, 0);
      step();
      releaseReset("boot");

`ifdef RAM_SEQ_INIT_SWEEP_EN
      rd_q.push_back(5'd7);
      runReads(20, lat, span, nrsp);
      checkOutput("swept_word_count", DW'(nrsp), 1);
`endif

      // Write then read back the next cycle
      doWrite(5'd3, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 5'd3, '0, 1'b1);
      checkOutput("wr_rd_ready", DW'(req_ready_o), 1);
      checkOutput("wr_rd_ram_we", DW'(ram_we_o), 0);
      step();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("wr_rd_n1_valid", DW'(rsp_valid_o), 0);
      step();
      checkOutput("wr_rd_n2_valid", DW'(rsp_valid_o), 1);
      checkOutput("wr_rd_n2_data", rsp_data_o, 32'hDEADBEEF);
      step();
      checkOutput("wr_rd_popped", DW'(rsp_valid_o), 0);

      // Throughput: 8 reads; credit rule gives 2 accepts per 3 cycles
      for (int a = 0; a < 8; a++) doWrite(AW'(a), 32'h100 + a);
      for (int a = 0; a < 8; a++) rd_q.push_back(AW'(a));
      runReads(60, lat, span, nrsp);
      checkOutput("tput_latency", DW'(lat), 2);
      checkOutput("tput_count", DW'(nrsp), 8);
      checkOutput("tput_span", DW'(span), 12);

      // Backpressure: consumer stalled, third read must wait for a pop
      applyStimulus(1'b1, 1'b0, 5'd0, '0, 1'b0);
      checkOutput("bp_a_ready", DW'(req_ready_o), 1);
      step();
      applyStimulus(1'b1, 1'b0, 5'd1, '0, 1'b0);
      checkOutput("bp_a1_ready", DW'(req_ready_o), 1);
      step();
      applyStimulus(1'b1, 1'b0, 5'd2, '0, 1'b0);
      checkOutput("bp_a2_stall", DW'(req_ready_o), 0);
      step();
      applyStimulus(1'b1, 1'b0, 5'd2, '0, 1'b0);
      checkOutput("bp_a3_stall", DW'(req_ready_o), 0);
      checkOutput("bp_a3_data", rsp_data_o, shadow[0]);
      step();
      applyStimulus(1'b1, 1'b0, 5'd2, '0, 1'b1);
      checkOutput("bp_a4_stall", DW'(req_ready_o), 0);
      checkOutput("bp_a4_data", rsp_data_o, shadow[0]);
      step();
      applyStimulus(1'b1, 1'b0, 5'd2, '0, 1'b1);
      checkOutput("bp_a5_ready", DW'(req_ready_o), 1);
      checkOutput("bp_a5_data", rsp_data_o, shadow[1]);
      step();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("bp_a6_valid", DW'(rsp_valid_o), 0);
      step();
      checkOutput("bp_a7_valid", DW'(rsp_valid_o), 1);
      checkOutput("bp_a7_data", rsp_data_o, shadow[2]);
      step();
      checkOutput("bp_a8_valid", DW'(rsp_valid_o), 0);

      // Read followed immediately by a write to the same word
      doWrite(5'd5, 32'h55);
      applyStimulus(1'b1, 1'b0, 5'd5, '0, 1'b1);
      checkOutput("il_rd_ready", DW'(req_ready_o), 1);
      step();
      applyStimulus(1'b1, 1'b1, 5'd5, 32'hAAAA, 1'b1);
      checkOutput("il_wr_ready", DW'(req_ready_o), 1);
      checkOutput("il_wr_we", DW'(ram_we_o), 1);
      shadow[5] = 32'hAAAA;
      step();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("il_rsp_valid", DW'(rsp_valid_o), 1);
      checkOutput("il_rsp_old", rsp_data_o, 32'h55);
      step();
      checkOutput("il_popped", DW'(rsp_valid_o), 0);
      rd_q.push_back(5'd5);
      runReads(20, lat, span, nrsp);
      checkOutput("il_new_count", DW'(nrsp), 1);

      // Reset with one response stored and one read in flight
      applyStimulus(1'b1, 1'b0, 5'd1, '0, 1'b0);
      step();
      applyStimulus(1'b1, 1'b0, 5'd2, '0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput("mid_pre_valid", DW'(rsp_valid_o), 1);
      #2 rst_i = 1'b1;
      #1;
      checkOutput("mid_rst_valid", DW'(rsp_valid_o), 0);
      checkOutput("mid_rst_ready", DW'(req_ready_o), 0);
      checkOutput("mid_rst_we", DW'(ram_we_o), 0);
      checkOutput("mid_rst_data", rsp_data_o, 0);
      step();
      releaseReset("mid");

      // Normal operation after the mid-flight reset
      doWrite(5'd9, 32'h12345678);
      rd_q.push_back(5'd9);
      runReads(20, lat, span, nrsp);
      checkOutput("post_rst_lat", DW'(lat), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
